// File: rtl/vec_exec_unit.sv
// Multi-cycle vector execution stage: latches one instruction, processes LANES
// elements per cycle from the register-file read ports, then writes back the full vector.
module vec_exec_unit #(
  parameter int ELEN  = 32,
  parameter int VLEN  = 64,
  parameter int LANES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [3:0]                 issue_op,
  input  logic [4:0]                 issue_vs1,
  input  logic [4:0]                 issue_vs2,
  input  logic [4:0]                 issue_vd,
  input  logic [$clog2(VLEN+1)-1:0]  issue_vl,
  input  logic                       issue_use_scalar,
  input  logic [ELEN-1:0]            issue_scalar,
  input  logic                       flush,
  output logic [4:0]                 rf_addr1,
  output logic [4:0]                 rf_addr2,
  input  logic [ELEN*VLEN-1:0]       rf_v1,
  input  logic [ELEN*VLEN-1:0]       rf_v2,
  output logic                       wb_en,
  output logic [4:0]                 wb_addr,
  output logic [ELEN*VLEN-1:0]       wb_data,
  output logic                       busy
);
  localparam int NBEATS = VLEN / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int VLW    = $clog2(VLEN + 1);
  localparam int SHW    = $clog2(ELEN);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t                     state_q, state_d;
  logic [BW-1:0]              beat_q;
  logic [3:0]                 op_q;
  logic [4:0]                 vs1_q, vs2_q, vd_q;
  logic [VLW-1:0]             vl_q;
  logic                       use_scalar_q;
  logic [ELEN-1:0]            scalar_q;
  logic [ELEN*VLEN-1:0]       res_buf;
  logic [LANES-1:0][ELEN-1:0] lane_res;

  function automatic logic [ELEN-1:0] alu(input logic [3:0] op,
                                          input logic [ELEN-1:0] a,
                                          input logic [ELEN-1:0] b);
    logic [SHW-1:0]         sh;
    logic signed [ELEN-1:0] sa;
    sh = b[SHW-1:0];
    sa = a;
    case (op)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      4'd2:    alu = a & b;
      4'd3:    alu = a | b;
      4'd4:    alu = a ^ b;
      4'd5:    alu = a << sh;
      4'd6:    alu = a >> sh;
      4'd7:    alu = sa >>> sh;
      4'd8:    alu = ($signed(a) < $signed(b)) ? a : b;
      4'd9:    alu = ($signed(a) > $signed(b)) ? a : b;
      4'd10:   alu = (a < b) ? a : b;
      4'd11:   alu = (a > b) ? a : b;
      4'd12:   alu = a * b;
      4'd13:   alu = b;
      default: alu = '0;
    endcase
  endfunction

  function automatic int elem_idx(input logic [BW-1:0] beat, input int k);
    return int'(beat) * LANES + k;
  endfunction

  // Elements at or beyond the active length are forced to zero (tail-zero).
  always_comb begin
    lane_res = '0;
    for (int k = 0; k < LANES; k++) begin
      if (elem_idx(beat_q, k) < int'(vl_q))
        lane_res[k] = alu(op_q, rf_v1[elem_idx(beat_q, k)*ELEN +: ELEN],
                          use_scalar_q ? scalar_q : rf_v2[elem_idx(beat_q, k)*ELEN +: ELEN]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue_valid) state_d = EXEC;
      EXEC: begin
        if (flush)                             state_d = IDLE;
        else if (beat_q == BW'(NBEATS - 1))    state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      op_q         <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd_q         <= '0;
      vl_q         <= '0;
      use_scalar_q <= 1'b0;
      scalar_q     <= '0;
      res_buf      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (issue_valid) begin
            op_q         <= issue_op;
            vs1_q        <= issue_vs1;
            vs2_q        <= issue_vs2;
            vd_q         <= issue_vd;
            vl_q         <= (issue_vl > VLW'(VLEN)) ? VLW'(VLEN) : issue_vl;
            use_scalar_q <= issue_use_scalar;
            scalar_q     <= issue_scalar;
          end
        end
        EXEC: begin
          res_buf[int'(beat_q)*LANES*ELEN +: LANES*ELEN] <= lane_res;
          beat_q <= beat_q + 1'b1;
        end
        default: beat_q <= '0;
      endcase
    end
  end

  // Handshake: an instruction transfers on a rising edge where issue_valid && issue_ready;
  // issue_ready is high only in IDLE and does not depend on issue_valid.
  assign issue_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rf_addr1    = (state_q == IDLE) ? 5'd0 : vs1_q;
  assign rf_addr2    = (state_q == IDLE) ? 5'd0 : vs2_q;
  assign wb_en       = (state_q == WB) && !flush;
  assign wb_addr     = (state_q == WB) ? vd_q : 5'd0;
  assign wb_data     = (state_q == WB) ? res_buf : '0;
endmodule

// File: tb/tb_vec_exec_unit.sv
// Bench for vec_exec_unit: register-file model, per-element reference model,
// directed boundary cases and randomized instructions.
module tb_vec_exec_unit;
  localparam int ELEN   = 32;
  localparam int VLEN   = 64;
  localparam int LANES  = 8;
  localparam int NBEATS = VLEN / LANES;
  localparam int VLW    = $clog2(VLEN + 1);
  localparam int VW     = ELEN * VLEN;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid, issue_ready, issue_use_scalar, flush;
  logic [3:0]      issue_op;
  logic [4:0]      issue_vs1, issue_vs2, issue_vd;
  logic [VLW-1:0]  issue_vl;
  logic [ELEN-1:0] issue_scalar;
  logic [4:0]      rf_addr1, rf_addr2, wb_addr;
  logic [VW-1:0]   rf_v1, rf_v2, wb_data;
  logic            wb_en, busy;

  logic [VW-1:0]   rf [32];
  logic [VW-1:0]   exp_q[$];
  logic [4:0]      exp_addr_q[$];
  logic [VW-1:0]   last_wb;
  int              checks = 0;
  int              errors = 0;

  vec_exec_unit #(.ELEN(ELEN), .VLEN(VLEN), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vd(issue_vd), .issue_vl(issue_vl),
    .issue_use_scalar(issue_use_scalar), .issue_scalar(issue_scalar), .flush(flush),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_v1(rf_v1), .rf_v2(rf_v2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign rf_v1 = rf[rf_addr1];
  assign rf_v2 = rf[rf_addr2];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    int idx;
    checks++;
    if (got !== exp) begin
      errors++;
      idx = 0;
      for (int e = VLEN - 1; e >= 0; e--)
        if (got[e*ELEN +: ELEN] !== exp[e*ELEN +: ELEN]) idx = e;
      $display("FAIL %s elem %0d got %h want %h", tag, idx,
               got[idx*ELEN +: ELEN], exp[idx*ELEN +: ELEN]);
    end
  endtask

  function automatic logic [ELEN-1:0] el(input logic [VW-1:0] v, input int e);
    return v[e*ELEN +: ELEN];
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [ELEN-1:0] ref_elem(input int op, input logic [ELEN-1:0] a,
                                               input logic [ELEN-1:0] b);
    logic [2*ELEN-1:0]      prod;
    logic signed [ELEN-1:0] sa, sb;
    int                     sh;
    sa = a;
    sb = b;
    sh = int'(b % ELEN);
    prod = {{ELEN{1'b0}}, a} * {{ELEN{1'b0}}, b};
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return sa >>> sh;
      8:  return (sa <= sb) ? a : b;
      9:  return (sa >= sb) ? a : b;
      10: return (a <= b) ? a : b;
      11: return (a >= b) ? a : b;
      12: return prod[ELEN-1:0];
      13: return b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [VW-1:0] ref_vec(input int op, input logic [VW-1:0] va,
                                            input logic [VW-1:0] vb, input int vl,
                                            input bit use_s, input logic [ELEN-1:0] scal);
    logic [VW-1:0] r;
    int            lim;
    r = '0;
    lim = (vl > VLEN) ? VLEN : vl;
    for (int e = 0; e < lim; e++)
      r[e*ELEN +: ELEN] = ref_elem(op, el(va, e), use_s ? scal : el(vb, e));
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_issue(input int op, input int vs1, input int vs2, input int vd,
                             input int vl, input bit use_s, input logic [ELEN-1:0] scal);
    issue_valid      = 1'b1;
    issue_op         = op[3:0];
    issue_vs1        = vs1[4:0];
    issue_vs2        = vs2[4:0];
    issue_vd         = vd[4:0];
    issue_vl         = vl[VLW-1:0];
    issue_use_scalar = use_s;
    issue_scalar     = scal;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":ready"}, issue_ready, 1);
    check({tag, ":busy"},  busy, 0);
    check({tag, ":wb_en"}, wb_en, 0);
    check({tag, ":wb_addr"}, wb_addr, 0);
    check({tag, ":wb_data"}, wb_data, '0);
    check({tag, ":addr1"}, rf_addr1, 0);
    check({tag, ":addr2"}, rf_addr2, 0);
  endtask

  // Issue one instruction and follow it to writeback; latency counted in cycles after acceptance.
  task automatic do_op(input string tag, input int op, input int vs1, input int vs2,
                       input int vd, input int vl, input bit use_s,
                       input logic [ELEN-1:0] scal, input bit idle_flush);
    int            lat;
    bit            seen;
    logic [VW-1:0] expv;
    logic [4:0]    expa;
    @(negedge clk);
    check({tag, ":ready"}, issue_ready, 1);
    drive_issue(op, vs1, vs2, vd, vl, use_s, scal);
    flush = idle_flush;
    exp_q.push_back(ref_vec(op, rf[vs1], rf[vs2], vl, use_s, scal));
    exp_addr_q.push_back(vd[4:0]);
    @(negedge clk);
    issue_valid = 1'b0;
    flush = 1'b0;
    check({tag, ":busy"}, busy, 1);
    check({tag, ":addr1"}, rf_addr1, vs1);
    check({tag, ":addr2"}, rf_addr2, vs2);
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      if (wb_en) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, ":latency"}, lat, NBEATS + 1);
    expv = exp_q.pop_front();
    expa = exp_addr_q.pop_front();
    if (seen) begin
      last_wb = wb_data;
      check({tag, ":wb_addr"}, wb_addr, expa);
      check({tag, ":wb_data"}, wb_data, expv);
      rf[vd] = expv;
      @(negedge clk);
      check({tag, ":wb_once"}, wb_en, 0);
      check({tag, ":ready_back"}, issue_ready, 1);
    end else begin
      last_wb = 'x;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    issue_valid = 1'b0;
    flush = 1'b0;
    drive_issue(0, 0, 0, 0, 0, 1'b0, '0);
    issue_valid = 1'b0;
    for (int r = 0; r < 32; r++)
      for (int e = 0; e < VLEN; e++) rf[r][e*ELEN +: ELEN] = $urandom;
    for (int e = 0; e < VLEN; e++) begin
      rf[1][e*ELEN +: ELEN] = ELEN'(e);
      rf[2][e*ELEN +: ELEN] = ELEN'(100 + e);
      rf[4][e*ELEN +: ELEN] = '0;
      rf[5][e*ELEN +: ELEN] = 32'h8000_0000;
      rf[6][e*ELEN +: ELEN] = 32'hFFFF_FFFF;
      rf[7][e*ELEN +: ELEN] = 32'h0001_0000;
    end
    repeat (3) @(negedge clk);
    check_reset_values("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_post");

    // directed cases
    do_op("add", 0, 1, 2, 3, 64, 1'b0, '0, 1'b0);
    check("add_e0", el(last_wb, 0), 100);
    check("add_e63", el(last_wb, 63), 226);
    do_op("sub_scalar", 1, 4, 2, 8, 64, 1'b1, 32'd1, 1'b0);
    check("sub_all_ones", last_wb, {VLEN{32'hFFFF_FFFF}});
    do_op("xor_vl10", 4, 1, 2, 10, 10, 1'b0, '0, 1'b0);
    check("xor_e9", el(last_wb, 9), 32'd9 ^ 32'd109);
    check("xor_e10_tail", el(last_wb, 10), 0);
    do_op("vl0", 0, 1, 2, 11, 0, 1'b0, '0, 1'b0);
    check("vl0_zero", last_wb, '0);
    do_op("vl_clamp", 0, 1, 2, 12, 100, 1'b0, '0, 1'b0);
    do_op("sra", 7, 5, 0, 13, 64, 1'b1, 32'd31, 1'b0);
    check("sra_val", el(last_wb, 0), 32'hFFFF_FFFF);
    do_op("min_s", 8, 6, 0, 14, 64, 1'b1, 32'd1, 1'b0);
    check("min_s_val", el(last_wb, 5), 32'hFFFF_FFFF);
    do_op("min_u", 10, 6, 0, 15, 64, 1'b1, 32'd1, 1'b0);
    check("min_u_val", el(last_wb, 5), 1);
    do_op("mul", 12, 7, 0, 16, 64, 1'b1, 32'h0001_0000, 1'b0);
    check("mul_val", el(last_wb, 7), 0);
    do_op("reserved", 14, 1, 2, 17, 64, 1'b0, '0, 1'b0);
    do_op("vd_eq_vs1", 0, 18, 19, 18, 64, 1'b0, '0, 1'b0);
    do_op("idle_flush", 3, 20, 21, 22, 33, 1'b0, '0, 1'b1);

    // flush in the middle of EXEC
    @(negedge clk);
    drive_issue(0, 1, 2, 9, 64, 1'b0, '0);
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (3) begin
      check("flush_exec_nowb", wb_en, 0);
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_exec_busy", busy, 0);
    check("flush_exec_ready", issue_ready, 1);
    repeat (12) begin
      check("flush_exec_nowb", wb_en, 0);
      @(negedge clk);
    end
    do_op("after_flush", 1, 2, 1, 9, 64, 1'b0, '0, 1'b0);

    // flush coinciding with the writeback cycle
    @(negedge clk);
    drive_issue(2, 1, 2, 23, 64, 1'b0, '0);
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (NBEATS) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_wb_gate", wb_en, 0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_wb_busy", busy, 0);
    check("flush_wb_nowb", wb_en, 0);

    // reset in the middle of EXEC, with a new instruction offered during reset
    @(negedge clk);
    drive_issue(0, 1, 2, 24, 64, 1'b0, '0);
    @(negedge clk);
    drive_issue(9, 3, 4, 25, 64, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    @(negedge clk);
    check("rst_no_accept", busy, 0);
    rst = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    check("rst_after_idle", busy, 0);
    check("rst_after_nowb", wb_en, 0);
    do_op("after_rst", 0, 1, 2, 26, 5, 1'b0, '0, 1'b0);

    // randomized instructions
    for (int i = 0; i < 30; i++)
      do_op("rand", $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 100), 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
